breath_key_ctrl: RTL and testbench



---
 rtl/breath_key_ctrl.sv | 141 ++++++++++++++
 tb/tb_breath_key_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/breath_key_ctrl.sv
// ============================================================================
// breath_key_ctrl : key debounce + 4-mode FSM driving dual breathing-LED enables
// Rev 1.0 | optional macro LONG_PRESS_EN: long hold forces mode OFF
// ============================================================================
`default_nettype none

module breath_key_ctrl #(
  parameter logic [19:0] DEBOUNCE_CNT_MAX = 20'd1_000_000,
  parameter logic [25:0] LONG_CNT_MAX     = 26'd50_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key,
  output logic [1:0] mode,
  output logic [1:0] led_en,
  output logic       mode_chg
);

  typedef enum logic [1:0] {
    S_OFF  = 2'b00,
    S_SLOW = 2'b01,
    S_FAST = 2'b10,
    S_BOTH = 2'b11
  } state_t;

  if (DEBOUNCE_CNT_MAX < 20'd1) begin : g_bad_debounce
    $error("DEBOUNCE_CNT_MAX must be at least 1");
  end
  if (LONG_CNT_MAX < 26'd2) begin : g_bad_long
    $error("LONG_CNT_MAX must be at least 2");
  end

  logic        key_sync1_q;
  logic        key_sync2_q;
  logic        key_stable_q;
  logic        key_stable_d;
  logic        key_stable_dly_q;
  logic [19:0] db_cnt_q;
  logic [19:0] db_cnt_d;
  state_t      state_q;
  state_t      state_d;
  logic [1:0]  led_en_q;
  logic [1:0]  led_en_d;
  logic        mode_chg_q;
  logic        mode_chg_d;
  logic        press;
  logic        long_hit;

  always_comb begin
    key_stable_d = key_stable_q;
    db_cnt_d     = '0;
    if (key_sync2_q != key_stable_q) begin
      if (db_cnt_q == DEBOUNCE_CNT_MAX - 20'd1) begin
        key_stable_d = key_sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 20'd1;
      end
    end
  end

  assign press = key_stable_dly_q & ~key_stable_q;

`ifdef LONG_PRESS_EN
  logic [25:0] long_cnt_q;
  logic [25:0] long_cnt_d;

  // Counter saturates at LONG_CNT_MAX so a continued hold fires only once.
  always_comb begin
    long_cnt_d = long_cnt_q;
    long_hit   = 1'b0;
    if (key_stable_q) begin
      long_cnt_d = '0;
    end else if (long_cnt_q < LONG_CNT_MAX) begin
      long_cnt_d = long_cnt_q + 26'd1;
      long_hit   = (long_cnt_q == LONG_CNT_MAX - 26'd1);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      long_cnt_q <= '0;
    end else begin
      long_cnt_q <= long_cnt_d;
    end
  end
`else
  assign long_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    mode_chg_d = 1'b0;
    if (long_hit) begin
      state_d    = S_OFF;
      mode_chg_d = (state_q != S_OFF);
    end else if (press) begin
      mode_chg_d = 1'b1;
      case (state_q)
        S_OFF:   state_d = S_SLOW;
        S_SLOW:  state_d = S_FAST;
        S_FAST:  state_d = S_BOTH;
        default: state_d = S_OFF;
      endcase
    end
    case (state_d)
      S_SLOW:  led_en_d = 2'b10;
      S_FAST:  led_en_d = 2'b01;
      S_BOTH:  led_en_d = 2'b11;
      default: led_en_d = 2'b00;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_sync1_q      <= 1'b1;
      key_sync2_q      <= 1'b1;
      key_stable_q     <= 1'b1;
      key_stable_dly_q <= 1'b1;
      db_cnt_q         <= '0;
      state_q          <= S_OFF;
      led_en_q         <= 2'b00;
      mode_chg_q       <= 1'b0;
    end else begin
      key_sync1_q      <= key;
      key_sync2_q      <= key_sync1_q;
      key_stable_q     <= key_stable_d;
      key_stable_dly_q <= key_stable_q;
      db_cnt_q         <= db_cnt_d;
      state_q          <= state_d;
      led_en_q         <= led_en_d;
      mode_chg_q       <= mode_chg_d;
    end
  end

  assign mode     = state_q;
  assign led_en   = led_en_q;
  assign mode_chg = mode_chg_q;

endmodule

`default_nettype wire

// File: tb/tb_breath_key_ctrl.sv
// Bench for breath_key_ctrl: directed scenarios plus random key activity,
// checked every cycle against a key-history window model.
`default_nettype none

module tb_breath_key_ctrl;

  localparam int DB = 10;
  localparam int LG = 40;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       key       = 1'b1;
  logic [1:0] mode;
  logic [1:0] led_en;
  logic       mode_chg;

  breath_key_ctrl #(
    .DEBOUNCE_CNT_MAX(20'd10),
    .LONG_CNT_MAX    (26'd40)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key      (key),
    .mode     (mode),
    .led_en   (led_en),
    .mode_chg (mode_chg)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pulses   = 0;
  int last_chg = -1;

  // Model state: raw key samples, debounced level, press pending, mode index.
  bit hist[$];
  bit m_stable;
  bit m_fell;
  int m_mode;
  bit m_chg;
  int m_low;
  logic [1:0] led_lut [4];

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    hist = {};
    for (int i = 0; i < DB + 2; i++) hist.push_back(1'b1);
    m_stable = 1'b1;
    m_fell   = 1'b0;
    m_mode   = 0;
    m_chg    = 1'b0;
    m_low    = 0;
  endtask

  // A debounced change happens once the samples that reached the second
  // synchroniser stage have all disagreed with the stable level DB times.
  task automatic model_step(input bit k);
    bit long_hit;
    bit all_diff;
    long_hit = 1'b0;
`ifdef LONG_PRESS_EN
    if (!m_stable) begin
      m_low++;
      if (m_low == LG) long_hit = 1'b1;
    end else begin
      m_low = 0;
    end
`endif
    m_chg = 1'b0;
    if (long_hit) begin
      m_chg  = (m_mode != 0);
      m_mode = 0;
    end else if (m_fell) begin
      m_mode = (m_mode + 1) % 4;
      m_chg  = 1'b1;
    end
    hist.push_back(k);
    if (hist.size() > DB + 2) void'(hist.pop_front());
    all_diff = 1'b1;
    for (int i = 0; i < DB; i++) if (hist[i] == m_stable) all_diff = 1'b0;
    m_fell = 1'b0;
    if (all_diff) begin
      m_fell   = m_stable;
      m_stable = ~m_stable;
    end
  endtask

  task automatic step(input bit k);
    key = k;
    @(posedge sys_clk);
    if (!sys_rst_n) model_reset();
    else model_step(k);
    cyc++;
    #1;
    chk("mode",     int'(mode),     m_mode);
    chk("led_en",   int'(led_en),   int'(led_lut[m_mode]));
    chk("mode_chg", int'(mode_chg), int'(m_chg));
    if (mode_chg) begin
      pulses++;
      last_chg = cyc;
    end
  endtask

  task automatic hold(input bit k, input int n);
    for (int i = 0; i < n; i++) step(k);
  endtask

  task automatic press_release(output int edge_cyc);
    edge_cyc = cyc;
    hold(1'b0, 30);
    hold(1'b1, 30);
  endtask

  initial begin
    int e;
    int p0;
    int r_len;
    bit r_val;
    led_lut[0] = 2'b00;
    led_lut[1] = 2'b10;
    led_lut[2] = 2'b01;
    led_lut[3] = 2'b11;
    model_reset();

    hold(1'b1, 5);
    sys_rst_n = 1'b1;
    hold(1'b1, 50);
    chk("idle_mode", int'(mode), 0);
    chk("idle_led", int'(led_en), 0);
    chk("idle_pulses", pulses, 0);

    press_release(e);
    chk("p1_latency", last_chg - e, 13);
    chk("p1_pulses", pulses, 1);
    chk("p1_mode", int'(mode), 1);
    chk("p1_led", int'(led_en), 2);

    press_release(e);
    chk("p2_mode", int'(mode), 2);
    chk("p2_led", int'(led_en), 1);
    press_release(e);
    chk("p3_mode", int'(mode), 3);
    chk("p3_led", int'(led_en), 3);
    press_release(e);
    chk("p4_mode", int'(mode), 0);
    chk("p4_led", int'(led_en), 0);
    chk("four_pulses", pulses, 4);

    // Bounce: 3-cycle segments L H L H L H, then a final low that settles.
    p0 = pulses;
    for (int s = 0; s < 6; s++) hold(s[0], 3);
    e = cyc;
    hold(1'b0, 30);
    hold(1'b1, 30);
    chk("bounce_pulses", pulses - p0, 1);
    chk("bounce_latency", last_chg - e, 13);
    chk("bounce_mode", int'(mode), 1);

    p0 = pulses;
    hold(1'b0, 8);
    hold(1'b1, 30);
    chk("short_pulses", pulses - p0, 0);
    chk("short_mode", int'(mode), 1);

    press_release(e);
    chk("fast_mode", int'(mode), 2);
    p0 = pulses;
    e = cyc;
    hold(1'b0, 100);
    hold(1'b1, 30);
`ifdef LONG_PRESS_EN
    chk("long_pulses", pulses - p0, 2);
    chk("long_mode", int'(mode), 0);
    chk("long_latency", last_chg - e, 52);
`else
    chk("long_pulses", pulses - p0, 1);
    chk("long_mode", int'(mode), 3);
`endif

    // Reset while the key is held, then keep holding: exactly one event.
    hold(1'b0, 20);
    sys_rst_n = 1'b0;
    hold(1'b0, 3);
    sys_rst_n = 1'b1;
    p0 = pulses;
    hold(1'b0, 30);
    chk("rst_hold_pulses", pulses - p0, 1);
    chk("rst_hold_mode", int'(mode), 1);
    hold(1'b1, 30);

    for (int n = 0; n < 200; n++) begin
      r_val = 1'($urandom_range(0, 1));
      r_len = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 9)
                                          : $urandom_range(10, 70);
      if ($urandom_range(0, 29) == 0) begin
        sys_rst_n = 1'b0;
        hold(r_val, $urandom_range(1, 3));
        sys_rst_n = 1'b1;
      end
      hold(r_val, r_len);
    end
    hold(1'b1, 30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
